inst_prefetch: RTL and testbench

- Instruction prefetch buffer upstream of the Y86 core.
- Pulls 32-bit words from instruction memory over a req/ack handshake and stores them as bytes in a circular byte queue.
- Presents a byte-aligned 80-bit instruction window at the current fetch PC, with decoded length and a valid flag.
- Replaces the direct ROM-to-core path; absorbs variable-latency instruction memory.

---
 rtl/inst_prefetch.sv | 211 +++++++++++++++++++++
 tb/tb_inst_prefetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: fetches 32-bit words over req/ack into a circular
// byte queue and presents an 80-bit instruction window. Optional INST_PREFETCH_ERR_EN flags bad icodes.
module inst_prefetch #(
  parameter int          BUF_BYTES = 16,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        take_i,
  output logic [79:0] inst_o,
  output logic [3:0]  inst_len_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic        inst_err_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_r;
  logic [7:0]         queue_r [BUF_BYTES];
  logic [PTR_W-1:0]   rdPtr_r;
  logic [PTR_W-1:0]   wrPtr_r;
  logic [CNT_W-1:0]   count_r;
  logic [31:0]        pc_r;
  logic [31:0]        fetchAddr_r;
  logic [1:0]         skip_r;
  logic               req_r;
  logic [31:0]        addr_r;

  logic [3:0]         icode_s;
  logic [3:0]         decLen_s;
  logic               instValid_s;
  logic               consume_s;
  logic               ackPush_s;
  logic               room_s;
  logic [CNT_W-1:0]   pushCnt_s;
  logic [CNT_W-1:0]   popCnt_s;
  logic [PTR_W-1:0]   wrIdx_s [4];
  logic [79:0]        window_s;

  function automatic logic [3:0] decodeLen(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1:       decodeLen = 4'd1;
      4'h2:             decodeLen = 4'd2;
      4'h3, 4'h4, 4'h5: decodeLen = 4'd6;
      4'h6:             decodeLen = 4'd2;
      4'h7, 4'h8:       decodeLen = 4'd5;
      4'h9:             decodeLen = 4'd1;
      4'hA, 4'hB:       decodeLen = 4'd2;
      default:          decodeLen = 4'd1;
    endcase
  endfunction

  // Decode the head instruction and the push/pop amounts for this cycle
  always_comb begin
    icode_s     = queue_r[rdPtr_r][7:4];
    decLen_s    = decodeLen(icode_s);
    instValid_s = (count_r != '0) && (count_r >= CNT_W'(decLen_s));
    consume_s   = take_i && instValid_s && !redirect_i;
    ackPush_s   = (state_r == WAIT) && imem_ack_i && !redirect_i;
    room_s      = count_r <= CNT_W'(BUF_BYTES - 4);
    if (ackPush_s) begin
      pushCnt_s = CNT_W'(3'd4) - CNT_W'(skip_r);
    end else begin
      pushCnt_s = '0;
    end
    if (consume_s) begin
      popCnt_s = CNT_W'(decLen_s);
    end else begin
      popCnt_s = '0;
    end
  end

  // Queue slots for word bytes skip..3, packed from the write pointer
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wrIdx_s[i] = wrPtr_r + PTR_W'(i) - PTR_W'(skip_r);
    end
  end

  // Window shows only bytes that are both queued and inside the instruction
  always_comb begin
    window_s = 80'h0;
    for (int k = 0; k < 10; k++) begin
      if ((CNT_W'(k) < count_r) && (4'(k) < decLen_s)) begin
        window_s[79-8*k -: 8] = queue_r[rdPtr_r + PTR_W'(k)];
      end else begin
        window_s[79-8*k -: 8] = 8'h00;
      end
    end
  end

  // Byte storage; contents beyond count are never observed, so no reset needed
  always_ff @(posedge clk) begin
    if (ackPush_s) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) >= skip_r) begin
          queue_r[wrIdx_s[i]] <= imem_data_i[8*i +: 8];
        end
      end
    end
  end

  // Queue bookkeeping, PC tracking and the fetch FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      req_r       <= 1'b0;
      addr_r      <= RESET_PC & 32'hFFFF_FFFC;
      fetchAddr_r <= RESET_PC & 32'hFFFF_FFFC;
      skip_r      <= RESET_PC[1:0];
      pc_r        <= RESET_PC;
      count_r     <= '0;
      rdPtr_r     <= '0;
      wrPtr_r     <= '0;
    end else begin
      if (redirect_i) begin
        count_r     <= '0;
        rdPtr_r     <= '0;
        wrPtr_r     <= '0;
        pc_r        <= redirect_pc_i;
        fetchAddr_r <= redirect_pc_i & 32'hFFFF_FFFC;
        skip_r      <= redirect_pc_i[1:0];
      end else begin
        count_r <= count_r - popCnt_s + pushCnt_s;
        rdPtr_r <= rdPtr_r + PTR_W'(popCnt_s);
        wrPtr_r <= wrPtr_r + PTR_W'(pushCnt_s);
        pc_r    <= pc_r + 32'(popCnt_s);
        if (ackPush_s) begin
          fetchAddr_r <= fetchAddr_r + 32'd4;
          skip_r      <= 2'd0;
        end
      end

      case (state_r)
        IDLE: begin
          if (room_s && !redirect_i) begin
            req_r   <= 1'b1;
            addr_r  <= fetchAddr_r;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          // An ack that coincides with a redirect is simply not pushed
          if (imem_ack_i) begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end else if (redirect_i) begin
            state_r <= DROP;
          end
        end
        DROP: begin
          if (imem_ack_i) begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef INST_PREFETCH_ERR_EN
  logic errNow_s;
  logic errSticky_r;

  // Invalid icode at the head of a complete instruction
  always_comb begin
    errNow_s = instValid_s && (icode_s > 4'hB);
  end

  // Sticky record of any invalid icode seen since the last redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      errSticky_r <= 1'b0;
    end else if (redirect_i) begin
      errSticky_r <= 1'b0;
    end else if (errNow_s) begin
      errSticky_r <= 1'b1;
    end
  end

  assign inst_err_o = errNow_s;
`else
  assign inst_err_o = 1'b0;
`endif

  assign inst_o       = window_s;
  assign inst_len_o   = (count_r != '0) ? decLen_s : 4'd0;
  assign inst_valid_o = instValid_s;
  assign pc_o         = pc_r;
  assign imem_req_o   = req_r;
  assign imem_addr_o  = addr_r;

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: small instruction-memory model plus
// hand-computed expectations for fill, nop streaming, redirects and error decode.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        take_i;
  logic [79:0] inst_o;
  logic [3:0]  inst_len_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic        inst_err_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  logic [31:0] mem [64];
  int          vecCount  = 0;
  int          missCount = 0;
  int          waitCnt   = 0;
  int          ackDelay  = 1;
  bit          manualMem = 1'b0;
  logic        expErr;

  inst_prefetch #(.BUF_BYTES(16), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .take_i       (take_i),
    .inst_o       (inst_o),
    .inst_len_o   (inst_len_o),
    .inst_valid_o (inst_valid_o),
    .pc_o         (pc_o),
    .inst_err_o   (inst_err_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i)
  );

  always #5 clk = ~clk;

  task automatic checkVec(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then let the memory model react
  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      imem_ack_i = 1'b0;
      waitCnt    = 0;
    end else if (!manualMem) begin
      if (imem_ack_i) begin
        imem_ack_i = 1'b0;
        waitCnt    = 0;
      end else if (imem_req_o) begin
        if (waitCnt >= ackDelay) begin
          imem_ack_i  = 1'b1;
          imem_data_i = mem[imem_addr_o[7:2]];
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  endtask

  initial begin
    bit   found;
    bit   seen4;
    logic [31:0] expPc;

    for (int i = 0; i < 64; i++) mem[i] = 32'h1010_1010;
    mem[0] = 32'h0000_1030;
    mem[1] = 32'h4433_2211;

`ifdef INST_PREFETCH_ERR_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif

    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; take_i = 1'b0;
    imem_ack_i = 1'b0; imem_data_i = 32'h0;
    cyc(); cyc();
    checkVec("rst_req",   imem_req_o,   1'b0);
    checkVec("rst_valid", inst_valid_o, 1'b0);
    checkVec("rst_inst",  inst_o,       80'h0);
    checkVec("rst_len",   inst_len_o,   4'd0);
    checkVec("rst_pc",    pc_o,         32'h0);
    checkVec("rst_err",   inst_err_o,   1'b0);
    rst = 1'b1;

    // First instruction 30 10 00 00 11 22 needs both words
    found = 1'b0; seen4 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (dut.count_r == 5'd4 && !seen4) begin
        seen4 = 1'b1;
        checkVec("fill_partial_valid", inst_valid_o, 1'b0);
        checkVec("fill_partial_len",   inst_len_o,   4'd6);
      end
      if (inst_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    checkVec("fill_valid_seen", found, 1'b1);
    checkVec("fill_count",      dut.count_r, 5'd8);
    checkVec("fill_inst",       inst_o, {48'h3010_0000_1122, 32'h0});
    checkVec("fill_len",        inst_len_o, 4'd6);
    checkVec("fill_pc",         pc_o, 32'h0);

    // Nop stream at 0x40 with take held, then stalled until full
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    cyc();
    redirect_i = 1'b0;
    checkVec("nop_redir_valid", inst_valid_o, 1'b0);
    checkVec("nop_redir_pc",    pc_o, 32'h40);
    expPc  = 32'h40;
    take_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (take_i && inst_valid_o) expPc = expPc + 32'd1;
      cyc();
      checkVec("nop_pc", pc_o, expPc);
      checkVec("nop_cnt_bound", dut.count_r <= 5'd16, 1'b1);
      if (imem_req_o) checkVec("nop_req_room", dut.count_r <= 5'd12, 1'b1);
      if (inst_valid_o) begin
        checkVec("nop_len",  inst_len_o, 4'd1);
        checkVec("nop_inst", inst_o, {8'h10, 72'h0});
      end
    end
    checkVec("nop_progress", expPc > 32'h48, 1'b1);
    take_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checkVec("stall_pc", pc_o, expPc);
      checkVec("stall_cnt_bound", dut.count_r <= 5'd16, 1'b1);
      if (imem_req_o) checkVec("stall_req_room", dut.count_r <= 5'd12, 1'b1);
    end
    checkVec("full_noreq",  imem_req_o, 1'b0);
    checkVec("full_cnt",    dut.count_r > 5'd12, 1'b1);

    // Hand-driven memory from here on
    manualMem  = 1'b1;
    imem_ack_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();
    redirect_i = 1'b0;
    checkVec("r200_valid", inst_valid_o, 1'b0);
    cyc();
    checkVec("r200_req",  imem_req_o, 1'b1);
    checkVec("r200_addr", imem_addr_o, 32'h200);

    // Redirect while waiting: late data must be dropped
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    cyc();
    redirect_i = 1'b0;
    checkVec("drop_req_held",  imem_req_o, 1'b1);
    checkVec("drop_addr_held", imem_addr_o, 32'h200);
    checkVec("drop_pc",        pc_o, 32'h103);
    checkVec("drop_valid",     inst_valid_o, 1'b0);
    cyc(); cyc();
    imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
    cyc();
    imem_ack_i = 1'b0;
    checkVec("drop_req_low", imem_req_o, 1'b0);
    checkVec("drop_count",   dut.count_r, 5'd0);
    cyc();
    checkVec("skip_req",  imem_req_o, 1'b1);
    checkVec("skip_addr", imem_addr_o, 32'h100);
    imem_ack_i = 1'b1; imem_data_i = 32'h1020_3040;
    cyc();
    imem_ack_i = 1'b0;
    checkVec("skip_pc",    pc_o, 32'h103);
    checkVec("skip_valid", inst_valid_o, 1'b1);
    checkVec("skip_len",   inst_len_o, 4'd1);
    checkVec("skip_inst",  inst_o, {8'h10, 72'h0});
    checkVec("skip_count", dut.count_r, 5'd1);
    cyc();
    checkVec("next_req",  imem_req_o, 1'b1);
    checkVec("next_addr", imem_addr_o, 32'h104);

    // Redirect and ack together: data discarded
    imem_ack_i = 1'b1; imem_data_i = 32'h1010_1010;
    redirect_i = 1'b1; redirect_pc_i = 32'h302;
    cyc();
    imem_ack_i = 1'b0; redirect_i = 1'b0;
    checkVec("coll_count", dut.count_r, 5'd0);
    checkVec("coll_valid", inst_valid_o, 1'b0);
    checkVec("coll_pc",    pc_o, 32'h302);
    checkVec("coll_req",   imem_req_o, 1'b0);
    cyc();
    checkVec("coll_next_req",  imem_req_o, 1'b1);
    checkVec("coll_next_addr", imem_addr_o, 32'h300);
    imem_ack_i = 1'b1; imem_data_i = 32'h1030_0000;
    cyc();
    imem_ack_i = 1'b0;
    checkVec("part_valid", inst_valid_o, 1'b0);
    checkVec("part_len",   inst_len_o, 4'd6);
    checkVec("part_count", dut.count_r, 5'd2);
    cyc();
    checkVec("w2_addr", imem_addr_o, 32'h304);
    imem_ack_i = 1'b1; imem_data_i = 32'h4433_2211;
    cyc();
    imem_ack_i = 1'b0;
    checkVec("six_valid", inst_valid_o, 1'b1);
    checkVec("six_len",   inst_len_o, 4'd6);
    checkVec("six_inst",  inst_o, {48'h3010_1122_3344, 32'h0});
    checkVec("six_pc",    pc_o, 32'h302);
    checkVec("six_count", dut.count_r, 5'd6);
    cyc();
    checkVec("w3_req",  imem_req_o, 1'b1);
    checkVec("w3_addr", imem_addr_o, 32'h308);

    // Take and ack in the same cycle: 6 - 6 + 4
    take_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'h1010_1010;
    cyc();
    take_i = 1'b0; imem_ack_i = 1'b0;
    checkVec("both_count", dut.count_r, 5'd4);
    checkVec("both_pc",    pc_o, 32'h308);
    checkVec("both_valid", inst_valid_o, 1'b1);
    checkVec("both_len",   inst_len_o, 4'd1);
    cyc();
    checkVec("w4_addr", imem_addr_o, 32'h30C);

    // Invalid icode F0 after four nops
    imem_ack_i = 1'b1; imem_data_i = 32'h0000_00F0;
    cyc();
    imem_ack_i = 1'b0;
    checkVec("err_fill_count", dut.count_r, 5'd8);
    take_i = 1'b1;
    repeat (4) cyc();
    take_i = 1'b0;
    checkVec("err_pc",    pc_o, 32'h30C);
    checkVec("err_valid", inst_valid_o, 1'b1);
    checkVec("err_len",   inst_len_o, 4'd1);
    checkVec("err_inst",  inst_o, {8'hF0, 72'h0});
    checkVec("err_flag",  inst_err_o, expErr);
    take_i = 1'b1;
    cyc();
    take_i = 1'b0;
    checkVec("after_err_pc",   pc_o, 32'h30D);
    checkVec("after_err_inst", inst_o, 80'h0);
    checkVec("after_err_flag", inst_err_o, 1'b0);
    checkVec("after_err_len",  inst_len_o, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
